// File: rtl/hex_display_driver.sv
// hex_display_driver: shows a 32-bit value on eight active-low 7-segment digits.
// The value is shown as hex or as unsigned decimal (sequential double-dabble), with leading-zero blanking and per-digit blinking.
module hex_display_driver #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int BLINK_HZ = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] value,
   input  logic        dec_mode,
   input  logic        blank_lz,
   input  logic [7:0]  blink_en,
   output logic [55:0] hex_n,
   output logic        busy
);
   localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int BW = HALF > 1 ? $clog2(HALF) : 1;
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;
   state_t        state_q;
   logic [32:0]   in_q, cur_q;
   logic          valid_q, ovf_q, phase_q, busy_q;
   logic [4:0]    cnt_q;
   logic [31:0]   sh_q, dig_q;
   logic [39:0]   bcd_q, bcd_d;
   logic [BW-1:0] blk_q;
   logic [55:0]   hex_q, hex_d;
   logic [7:0]    nz;
   always_comb begin
      bcd_d = bcd_q;
      for (int k = 0; k < 10; k++)
         bcd_d[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         in_q    <= '0;
         cur_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
         bcd_q   <= '0;
         dig_q   <= '0;
      end else begin
         in_q <= {dec_mode, value};
         case (state_q)
            IDLE: if (!valid_q || in_q != cur_q) begin
               cur_q   <= in_q;
               valid_q <= 1'b1;
               busy_q  <= 1'b1;
               sh_q    <= in_q[31:0];
               bcd_q   <= '0;
               cnt_q   <= '0;
               state_q <= in_q[32] ? CONVERT : LOAD;
            end
            CONVERT: begin
               bcd_q   <= {bcd_d[38:0], sh_q[31]};
               sh_q    <= sh_q << 1;
               cnt_q   <= cnt_q + 5'd1;
               state_q <= cnt_q == 5'd31 ? LOAD : CONVERT;
            end
            default: begin
               dig_q   <= cur_q[32] ? bcd_q[31:0] : cur_q[31:0];
               ovf_q   <= cur_q[32] && |bcd_q[39:32];
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   // nz[i]: some digit at position i or above is nonzero
   always_comb begin
      nz    = '0;
      hex_d = '1;
      for (int i = 0; i < 8; i++) begin
         nz[i] = |(dig_q >> (4 * i));
         hex_d[7*i +: 7] = (phase_q && blink_en[i]) ? 7'h7F :
                           ovf_q ? 7'h3F :
                           (blank_lz && i != 0 && !nz[i]) ? 7'h7F : SEG[dig_q[4*i +: 4]];
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         blk_q   <= '0;
         phase_q <= 1'b0;
         hex_q   <= '1;
      end else begin
         blk_q   <= blk_q == BW'(HALF - 1) ? '0 : blk_q + 1'b1;
         phase_q <= phase_q ^ (blk_q == BW'(HALF - 1));
         hex_q   <= hex_d;
      end
   assign hex_n = hex_q;
   assign busy  = busy_q;
endmodule

// File: tb/tb_hex_display_driver.sv
// tb_hex_display_driver: directed vectors against an arithmetic display model plus literal expectations.
module tb_hex_display_driver;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [31:0] value = '0;
   logic        dec_mode = 1'b0, blank_lz = 1'b1;
   logic [7:0]  blink_en = '0;
   logic [55:0] hex_n;
   logic        busy;
   int          n_chk = 0, n_fail = 0;
   bit          chk = 1'b0, exp_dec = 1'b0;
   logic [31:0] exp_v = '0;
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   always #5 clk = ~clk;
   hex_display_driver #(.CLK_HZ(8), .BLINK_HZ(1)) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .dec_mode(dec_mode),
      .blank_lz(blank_lz), .blink_en(blink_en), .hex_n(hex_n), .busy(busy)
   );
   function automatic logic [55:0] model(input logic [31:0] v, input bit dec, input bit lz);
      longint unsigned q = v;
      int              msd = 0;
      int              d [8];
      logic [55:0]     r;
      for (int i = 0; i < 8; i++) begin
         d[i] = dec ? int'(q % 10) : int'(q % 16);
         q = dec ? q / 10 : q / 16;
         if (d[i] != 0) msd = i;
      end
      for (int i = 0; i < 8; i++)
         r[7*i +: 7] = (dec && v >= 100_000_000) ? 7'h3F : (lz && i > msd) ? 7'h7F : SEG[d[i]];
      return r;
   endfunction
   task automatic check(input string name, input logic [55:0] act, input logic [55:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   always @(negedge clk)
      if (chk) begin
         check("steady_hex", hex_n, model(exp_v, exp_dec, blank_lz));
         check("steady_busy", 56'(busy), 56'd0);
      end
   task automatic apply(input string name, input logic [31:0] v, input bit dec, input int lat);
      logic [55:0] prev, want;
      int          b = 0;
      chk = 1'b0;
      prev = hex_n;
      want = model(v, dec, blank_lz);
      value = v;
      dec_mode = dec;
      for (int k = 1; k <= lat; k++) begin
         step(1);
         b += int'(busy);
         if (k == lat - 1 && prev !== want) check({name, "_early"}, hex_n, prev);
      end
      check(name, hex_n, want);
      check({name, "_busy"}, 56'(b), dec ? 56'd33 : 56'd1);
      exp_v = v;
      exp_dec = dec;
      chk = 1'b1;
   endtask
   initial begin
      logic [6:0]  s [16];
      logic [48:0] up [16];
      logic [55:0] want;
      int          b;
      bit          ok;
      step(1);
      check("reset_hex", hex_n, '1);
      check("reset_busy", 56'(busy), 56'd0);
      reset_n = 1'b1;
      step(10);
      check("idle_zero", hex_n, {{7{7'h7F}}, 7'h40});
      chk = 1'b1;
      apply("hex_a5", 32'hA5, 1'b0, 4);
      check("hex_a5_lit", hex_n, {{6{7'h7F}}, 7'h08, 7'h12});
      apply("hex_f00d", 32'h0000F00D, 1'b0, 4);
      apply("hex_deadbeef", 32'hDEADBEEF, 1'b0, 4);
      check("hex_deadbeef_lit", hex_n, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
      apply("dec_12345678", 32'd12_345_678, 1'b1, 36);
      check("dec_12345678_lit", hex_n, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
      apply("dec_99999999", 32'd99_999_999, 1'b1, 36);
      check("dec_99999999_lit", hex_n, {8{7'h10}});
      apply("dec_ovf", 32'd100_000_000, 1'b1, 36);
      check("dec_ovf_lit", hex_n, {8{7'h3F}});
      apply("dec_max", 32'hFFFF_FFFF, 1'b1, 36);
      apply("dec_zero", 32'd0, 1'b1, 36);
      check("dec_zero_lit", hex_n, {{7{7'h7F}}, 7'h40});
      chk = 1'b0;
      blank_lz = 1'b0;
      b = 0;
      for (int k = 0; k < 4; k++) begin
         step(1);
         b += int'(busy);
      end
      check("lz_off_lit", hex_n, {8{7'h40}});
      check("lz_off_no_conv", 56'(b), 56'd0);
      chk = 1'b1;
      apply("dec_lz_off", 32'd1_000_050, 1'b1, 36);
      chk = 1'b0;
      blank_lz = 1'b1;
      step(2);
      chk = 1'b1;
      step(3);
      chk = 1'b0;
      b = 0;
      value = 32'd1234;
      for (int k = 1; k <= 70; k++) begin
         step(1);
         b += int'(busy);
         if (k == 12) value = 32'd5678;
         if (k == 36) check("retrig_first", hex_n, model(32'd1234, 1'b1, 1'b1));
         if (k == 69) check("retrig_hold", hex_n, model(32'd1234, 1'b1, 1'b1));
      end
      check("retrig_final", hex_n, {{4{7'h7F}}, 7'h12, 7'h02, 7'h78, 7'h00});
      check("retrig_busy", 56'(b), 56'd66);
      exp_v = 32'd5678;
      chk = 1'b1;
      step(2);
      chk = 1'b0;
      blink_en = 8'h01;
      step(2);
      for (int k = 0; k < 16; k++) begin
         step(1);
         s[k] = hex_n[6:0];
         up[k] = hex_n[55:7];
      end
      want = model(32'd5678, 1'b1, 1'b1);
      for (int k = 4; k < 16; k++) begin
         ok = s[k] !== s[k-4] && (s[k] === 7'h00 || s[k] === 7'h7F) && (k < 8 || s[k] === s[k-8]);
         n_chk++;
         if (!ok) begin
            n_fail++;
            $display("FAIL blink_d0[%0d]: got %h (4 back %h) expected 4-on/4-off of 00/7F", k, s[k], s[k-4]);
         end
      end
      for (int k = 0; k < 16; k++) check("blink_upper", 56'(up[k]), 56'(want[55:7]));
      blink_en = 8'h00;
      step(2);
      value = 32'd87_654_321;
      step(10);
      reset_n = 1'b0;
      #1;
      check("async_rst_hex", hex_n, '1);
      check("async_rst_busy", 56'(busy), 56'd0);
      #2 reset_n = 1'b1;
      step(80);
      check("post_rst_lit", hex_n, {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
      check("post_rst_busy", 56'(busy), 56'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
